chicken_turn_engine: RTL and testbench
======================================

Name: chicken_turn_engine

Overview:
- Upstream stage of the game data path. Owns the board tile map, each player's chicken position and the current-turn index T.
- Presents the image of the tile the current chicken must match (position_data) and accepts the player's flipped-card image.
- Produces the match flag (A), move strobe, next-turn strobe (statecombo_next_turn) and positions consumed by the same/win/next-turn checking logic.

Parameters:
- NUM_TILES, 16, track length; positions wrap modulo NUM_TILES; must be a power of two.
- POS_W, 4, position width, equal to log2(NUM_TILES).
- IMG_W, 4, tile/card image width.
- TILE_MAP, {16 x 4-bit, tile i image = i mod 8}, packed tile images; tile i is in bits [i*IMG_W +: IMG_W].

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; (re)initialises a game.
- N  in  2  highest active player index; 0 and 1 both mean players 0..1; 2 means 0..2; 3 means 0..3.
- game_over  in  1  level; freezes the engine.
- flip_valid  in  1  one-cycle pulse; flip_card is valid.
- flip_card  in  IMG_W  image of the flipped card.
- T  out  2  current player.
- position_data  out  IMG_W  image of the current target tile.
- target_pos  out  POS_W  index of the target tile.
- A  out  1  result of the last comparison (1 = match).
- move_strobe  out  1  one-cycle pulse when the current chicken advanced.
- statecombo_next_turn  out  1  one-cycle pulse when the turn passed.
- pos_flat  out  4*POS_W  chicken positions; player p in bits [p*POS_W +: POS_W].
- ready  out  1  high only in WAIT_FLIP.

Behaviour:
- Reset: state IDLE; T=0; A=0; both strobes 0; position_data=0; target_pos=0; ready=0; pos[p]=4*p.
- FSM states: IDLE, SEEK, WAIT_FLIP, RESOLVE, HOLD.
- IDLE -> SEEK on start. Entering SEEK from start: pos[p]=4*p, T=0, A=0.
- Target computation (SEEK, one cycle):
  - Target = (pos[T]+1) mod NUM_TILES.
  - Skip the target while it is occupied by another active player (index <= effective N, not T). Up to 3 skips, evaluated combinationally.
  - Register target_pos and position_data = TILE_MAP[target]. Then go to WAIT_FLIP.
- WAIT_FLIP:
  - ready=1.
  - On flip_valid: A <= (flip_card == position_data); go to RESOLVE.
  - flip_valid in any other state is ignored.
- RESOLVE (one cycle):
  - Match: pos[T] <= target_pos; move_strobe=1 for exactly the next cycle.
  - Miss: T <= (T == effective N) ? 0 : T+1; statecombo_next_turn=1 for exactly the next cycle.
  - Either way, go to SEEK.
- Latency: flip_valid sampled at edge e0 -> A valid after e0 -> pos/T and strobes after e1 -> new position_data and ready after e2.
- game_over high in any state: go to HOLD at the next edge. Outputs hold their values; strobes are forced 0. HOLD exits only on start, which behaves as from IDLE.
- start in any non-IDLE state restarts the game and overrides a pending flip.
- Simultaneous start and game_over: start wins.
- Position wrap: pos 15 advancing goes to 0.
- Inactive players' positions are held and never block the track.
- Changing N mid-game takes effect at the next SEEK. If T > effective N at that point, T wraps to 0 on the next miss.
- Reset mid-operation forces reset values immediately; no strobe is emitted.

Decomposition:
- Shared game package holds: state encodings, IMG_W/POS_W constants, default TILE_MAP, and the effective-N function (N==0 -> 1).
- One sub-module, chicken_target_finder: combinational. Inputs are positions, T and effective N; output is the target index with occupied-tile skipping.

Test Plan:
- Reset then start, N=1 -> T=0, target_pos=1, position_data=1, ready=1 after 2 cycles; pos_flat = {12,8,4,0}.
- flip_card=1 in WAIT_FLIP -> A=1, move_strobe pulse, pos0=1, next position_data=2. flip_card=5 -> A=0, statecombo_next_turn pulse, T=1, target_pos=5.
- Skip case: player 0 matches 1,2,3 (pos0=3) with player1 at 4 -> target_pos=5, position_data=5. With N=3 and players at 3,4,5(player2) -> target 6.
- Turn wrap: N=1, misses alternate T 0->1->0. N=0 behaves identically. N=3: T cycles 0->1->2->3->0.
- Position wrap: drive player 3 from 12 through matches to 15 -> next target 0 (image 0) if player 0 is not at 0; if player 0 is at 0, target skips to 1.
- game_over mid-RESOLVE -> no strobe, outputs frozen, flip ignored. Start while game_over high -> reinit as after reset. Async rst asserted mid-WAIT_FLIP -> immediate reset values.

Source files
------------

// File: rtl/chicken_turn_engine_pkg.sv
// Shared definitions for the chicken turn engine: FSM encoding, default track sizing,
// default tile map and the effective player-count helper.
package chicken_turn_engine_pkg;

    localparam int DEF_NUM_TILES = 16;
    localparam int DEF_POS_W     = 4;
    localparam int DEF_IMG_W     = 4;

    // Tile i shows image (i mod 8); tile i lives in bits [i*IMG_W +: IMG_W].
    localparam logic [DEF_NUM_TILES*DEF_IMG_W-1:0] DEF_TILE_MAP = 64'h7654_3210_7654_3210;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEEK,
        ST_WAIT_FLIP,
        ST_RESOLVE,
        ST_HOLD
    } state_t;

    // N == 0 still means a two-player game.
    function automatic logic [1:0] eff_n(input logic [1:0] n);
        return (n == 2'd0) ? 2'd1 : n;
    endfunction

endpackage

// File: rtl/chicken_target_finder.sv
// Combinational target search: the tile after the current chicken, stepping past
// tiles held by other active players (at most three can be in the way).
module chicken_target_finder
    import chicken_turn_engine_pkg::*;
#(
    parameter int NUM_TILES = DEF_NUM_TILES,
    parameter int POS_W     = DEF_POS_W
) (
    input  logic [4*POS_W-1:0] pos_flat,
    input  logic [1:0]         turn,
    input  logic [1:0]         n_eff,
    output logic [POS_W-1:0]   target
);

    always_comb begin
        logic [POS_W-1:0] cand;
        logic             occ;
        cand = POS_W'((32'(pos_flat[turn*POS_W +: POS_W]) + 1) % NUM_TILES);
        occ  = 1'b0;
        for (int s = 0; s < 3; s++) begin
            occ = 1'b0;
            for (int p = 0; p < 4; p++) begin
                if ((2'(p) <= n_eff) && (2'(p) != turn) &&
                    (pos_flat[p*POS_W +: POS_W] == cand))
                    occ = 1'b1;
            end
            if (occ)
                cand = POS_W'((32'(cand) + 1) % NUM_TILES);
        end
        target = cand;
    end

endmodule

// File: rtl/chicken_turn_engine.sv
// Turn engine: owns chicken positions and the turn index, presents the target tile
// image and resolves each flipped card into a move or a turn hand-over.
//
// state     | meaning
// ----------|------------------------------------------------------------
// IDLE      | after reset, waiting for start
// SEEK      | register target tile and its image for the current player
// WAIT_FLIP | ready high, waiting for the flipped card
// RESOLVE   | apply match (advance chicken) or miss (pass the turn)
// HOLD      | game over, everything frozen until start
module chicken_turn_engine
    import chicken_turn_engine_pkg::*;
#(
    parameter int                           NUM_TILES = DEF_NUM_TILES,
    parameter int                           POS_W     = DEF_POS_W,
    parameter int                           IMG_W     = DEF_IMG_W,
    parameter logic [NUM_TILES*IMG_W-1:0]   TILE_MAP  = DEF_TILE_MAP
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           N,
    input  logic                 game_over,
    input  logic                 flip_valid,
    input  logic [IMG_W-1:0]     flip_card,
    output logic [1:0]           T,
    output logic [IMG_W-1:0]     position_data,
    output logic [POS_W-1:0]     target_pos,
    output logic                 A,
    output logic                 move_strobe,
    output logic                 statecombo_next_turn,
    output logic [4*POS_W-1:0]   pos_flat,
    output logic                 ready
);

    function automatic logic [4*POS_W-1:0] init_pos();
        logic [4*POS_W-1:0] v;
        v = '0;
        for (int p = 0; p < 4; p++)
            v[p*POS_W +: POS_W] = POS_W'(4 * p);
        return v;
    endfunction

    state_t             state;
    logic [4*POS_W-1:0] pos_q;
    logic [1:0]         n_eff;
    logic [POS_W-1:0]   target_next;

    assign n_eff    = eff_n(N);
    assign pos_flat = pos_q;

    chicken_target_finder #(
        .NUM_TILES (NUM_TILES),
        .POS_W     (POS_W)
    ) u_finder (
        .pos_flat (pos_q),
        .turn     (T),
        .n_eff    (n_eff),
        .target   (target_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                <= ST_IDLE;
            pos_q                <= init_pos();
            T                    <= 2'd0;
            A                    <= 1'b0;
            move_strobe          <= 1'b0;
            statecombo_next_turn <= 1'b0;
            position_data        <= '0;
            target_pos           <= '0;
            ready                <= 1'b0;
        end else begin
            move_strobe          <= 1'b0;
            statecombo_next_turn <= 1'b0;
            // start outranks game_over and any pending flip.
            if (start) begin
                state <= ST_SEEK;
                pos_q <= init_pos();
                T     <= 2'd0;
                A     <= 1'b0;
                ready <= 1'b0;
            end else if (game_over) begin
                state <= ST_HOLD;
                ready <= 1'b0;
            end else begin
                case (state)
                    ST_SEEK: begin
                        target_pos    <= target_next;
                        position_data <= TILE_MAP[int'(target_next)*IMG_W +: IMG_W];
                        ready         <= 1'b1;
                        state         <= ST_WAIT_FLIP;
                    end
                    ST_WAIT_FLIP: begin
                        if (flip_valid) begin
                            A     <= (flip_card == position_data);
                            ready <= 1'b0;
                            state <= ST_RESOLVE;
                        end
                    end
                    ST_RESOLVE: begin
                        if (A) begin
                            pos_q[T*POS_W +: POS_W] <= target_pos;
                            move_strobe             <= 1'b1;
                        end else begin
                            // >= also covers T left stranded above a reduced N.
                            T                    <= (T >= n_eff) ? 2'd0 : T + 2'd1;
                            statecombo_next_turn <= 1'b1;
                        end
                        state <= ST_SEEK;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_chicken_turn_engine.sv
// Directed bench for chicken_turn_engine with hand-computed expectations.
module tb_chicken_turn_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  N = 2'd1;
    logic        game_over = 1'b0;
    logic        flip_valid = 1'b0;
    logic [3:0]  flip_card = 4'd0;
    logic [1:0]  T;
    logic [3:0]  position_data;
    logic [3:0]  target_pos;
    logic        A;
    logic        move_strobe;
    logic        statecombo_next_turn;
    logic [15:0] pos_flat;
    logic        ready;

    int tests  = 0;
    int failed = 0;

    chicken_turn_engine dut (
        .clk                  (clk),
        .rst                  (rst),
        .start                (start),
        .N                    (N),
        .game_over            (game_over),
        .flip_valid           (flip_valid),
        .flip_card            (flip_card),
        .T                    (T),
        .position_data        (position_data),
        .target_pos           (target_pos),
        .A                    (A),
        .move_strobe          (move_strobe),
        .statecombo_next_turn (statecombo_next_turn),
        .pos_flat             (pos_flat),
        .ready                (ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [1:0] n);
        N     = n;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
    endtask

    task automatic flip(input logic [3:0] card);
        flip_valid = 1'b1;
        flip_card  = card;
        tick();
        flip_valid = 1'b0;
    endtask

    task automatic turn(input logic [3:0] card);
        flip(card);
        tick();
        tick();
    endtask

    initial begin
        #12;
        chk("rst_T", 32'(T), 0);
        chk("rst_A", 32'(A), 0);
        chk("rst_ready", 32'(ready), 0);
        chk("rst_tp", 32'(target_pos), 0);
        chk("rst_pd", 32'(position_data), 0);
        chk("rst_pos", 32'(pos_flat), 32'hC840);
        chk("rst_strobes", {30'd0, move_strobe, statecombo_next_turn}, 0);
        tick();
        rst = 1'b0;
        tick();

        // basic match / miss with N=1
        do_start(2'd1);
        chk("start_ready", 32'(ready), 1);
        chk("start_T", 32'(T), 0);
        chk("start_tp", 32'(target_pos), 1);
        chk("start_pd", 32'(position_data), 1);
        chk("start_pos", 32'(pos_flat), 32'hC840);
        flip(4'd1);
        chk("match_A", 32'(A), 1);
        tick();
        chk("match_strobe", 32'(move_strobe), 1);
        chk("match_pos", 32'(pos_flat), 32'hC841);
        tick();
        chk("match_strobe_off", 32'(move_strobe), 0);
        chk("match_ready", 32'(ready), 1);
        chk("match_tp", 32'(target_pos), 2);
        chk("match_pd", 32'(position_data), 2);
        flip(4'd5);
        chk("miss_A", 32'(A), 0);
        tick();
        chk("miss_nt", 32'(statecombo_next_turn), 1);
        chk("miss_T", 32'(T), 1);
        tick();
        chk("miss_nt_off", 32'(statecombo_next_turn), 0);
        chk("miss_tp", 32'(target_pos), 5);
        chk("miss_pd", 32'(position_data), 5);
        turn(4'd0);
        chk("wrap_n1_T", 32'(T), 0);
        turn(4'd2);
        turn(4'd3);
        chk("skip1_tp", 32'(target_pos), 5);
        chk("skip1_pd", 32'(position_data), 5);

        // restart mid-game, N=0 behaves like N=1
        do_start(2'd0);
        chk("n0_pos", 32'(pos_flat), 32'hC840);
        chk("n0_tp", 32'(target_pos), 1);
        turn(4'd0);
        chk("n0_T1", 32'(T), 1);
        turn(4'd0);
        chk("n0_T0", 32'(T), 0);

        // four players: turn cycling and skipping over one or two chickens
        do_start(2'd3);
        turn(4'd0);
        chk("n3_T1", 32'(T), 1);
        turn(4'd5);
        turn(4'd6);
        turn(4'd7);
        chk("n3_p1_skip_tp", 32'(target_pos), 9);
        chk("n3_p1_skip_pd", 32'(position_data), 1);
        turn(4'd0);
        chk("n3_T2", 32'(T), 2);
        turn(4'd0);
        chk("n3_T3", 32'(T), 3);
        turn(4'd0);
        chk("n3_T0", 32'(T), 0);
        for (int i = 1; i <= 6; i++)
            turn(4'(i));
        chk("skip2_tp", 32'(target_pos), 9);
        chk("skip2_pd", 32'(position_data), 1);
        chk("skip2_pos", 32'(pos_flat), 32'hC876);
        turn(4'd0);
        turn(4'd0);
        turn(4'd0);
        chk("p3_T", 32'(T), 3);
        chk("p3_tp", 32'(target_pos), 13);
        turn(4'd5);
        turn(4'd6);
        turn(4'd7);
        chk("wrap_tp", 32'(target_pos), 0);
        chk("wrap_pd", 32'(position_data), 0);
        chk("wrap_pos", 32'(pos_flat), 32'hF876);

        // wrap onto an occupied tile 0
        do_start(2'd3);
        turn(4'd0);
        turn(4'd0);
        turn(4'd0);
        turn(4'd5);
        turn(4'd6);
        turn(4'd7);
        chk("wrap_skip_tp", 32'(target_pos), 1);
        chk("wrap_skip_pd", 32'(position_data), 1);
        turn(4'd1);
        chk("wrap_skip_pos", 32'(pos_flat), 32'h1840);
        chk("wrap_next_tp", 32'(target_pos), 2);

        // game_over during RESOLVE
        flip(4'd2);
        chk("go_A", 32'(A), 1);
        game_over = 1'b1;
        tick();
        chk("go_strobe", 32'(move_strobe), 0);
        chk("go_pos", 32'(pos_flat), 32'h1840);
        chk("go_ready", 32'(ready), 0);
        flip(4'd0);
        tick();
        chk("go_flip_A", 32'(A), 1);
        chk("go_flip_pos", 32'(pos_flat), 32'h1840);
        chk("go_flip_T", 32'(T), 3);
        chk("go_flip_nt", 32'(statecombo_next_turn), 0);
        start = 1'b1;
        tick();
        start     = 1'b0;
        game_over = 1'b0;
        chk("go_start_pos", 32'(pos_flat), 32'hC840);
        chk("go_start_T", 32'(T), 0);
        chk("go_start_A", 32'(A), 0);
        tick();
        chk("go_start_ready", 32'(ready), 1);
        chk("go_start_tp", 32'(target_pos), 1);

        // async reset while waiting for a flip
        turn(4'd1);
        chk("pre_rst_A", 32'(A), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_ready", 32'(ready), 0);
        chk("arst_A", 32'(A), 0);
        chk("arst_pos", 32'(pos_flat), 32'hC840);
        chk("arst_tp", 32'(target_pos), 0);
        chk("arst_pd", 32'(position_data), 0);
        chk("arst_T", 32'(T), 0);
        tick();
        rst = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
